// File: rtl/io_port_bridge_if.sv
`timescale 1ns/1ps
// CPU-side bus, UART RX/TX handshakes and stop flag seen by io_port_bridge.
interface io_port_bridge_if;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        rdy_out;
    logic [7:0]  ram_din;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        prog_stop;

    modport slave (
        input  cpu_a, cpu_dout, cpu_wr, ram_din, rx_valid, rx_data, tx_ready,
        output cpu_din, rdy_out, rx_ready, tx_valid, tx_data, prog_stop
    );

    modport master (
        output cpu_a, cpu_dout, cpu_wr, ram_din, rx_valid, rx_data, tx_ready,
        input  cpu_din, rdy_out, rx_ready, tx_valid, tx_data, prog_stop
    );
endinterface

// File: rtl/io_port_bridge.sv
`timescale 1ns/1ps
// Decodes the 0x3xxxx I/O region of the cpu bus: TX FIFO on reg0 writes,
// RX byte / cycle-counter reads, and the reg4 drain-then-stop sequence.
module io_port_bridge #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 32
) (
    input logic             clk_in,
    input logic             rst_in,
    io_port_bridge_if.slave bus
);
    localparam int unsigned     PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_STOPPED} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_RX, SRC_CNT} src_t;

    state_t             state_q, state_d;
    src_t               src_q, src_d;
    logic [1:0]         lane_q, lane_d;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   snap_q, snap_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    logic       is_io, is_reg0, is_reg4;
    logic       full, empty, rdy, rd_acc, wr_acc;
    logic       push, pop, tx_valid_int;
    logic [7:0] push_data;

    always_comb begin
        is_io        = (bus.cpu_a[17:16] == 2'b11);
        is_reg0      = is_io && !bus.cpu_a[2];
        is_reg4      = is_io && bus.cpu_a[2];
        full         = (count_q == DEPTH_CNT);
        empty        = (count_q == '0);
        // Any I/O write stalls on a full FIFO; a pop this cycle does not help.
        rdy          = rst_in && (state_q == ST_RUN) && !(full && is_io && bus.cpu_wr);
        rd_acc       = rdy && !bus.cpu_wr;
        wr_acc       = rdy && bus.cpu_wr;
        push         = wr_acc && (is_reg4 || (is_reg0 && (bus.cpu_dout != 8'h00)));
        push_data    = is_reg4 ? 8'h00 : bus.cpu_dout;
        tx_valid_int = !empty && (state_q != ST_STOPPED);
        pop          = tx_valid_int && bus.tx_ready;
    end

    always_comb begin
        state_d   = state_q;
        src_d     = SRC_NONE;
        lane_d    = lane_q;
        rx_byte_d = rx_byte_q;
        snap_d    = snap_q;
        cnt_d     = cnt_q + CNT_W'(1);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (rd_acc) begin
            lane_d = bus.cpu_a[1:0];
            if (is_reg0) begin
                src_d     = SRC_RX;
                rx_byte_d = bus.rx_valid ? bus.rx_data : 8'h00;
            end else if (is_reg4) begin
                src_d = SRC_CNT;
                if (bus.cpu_a[1:0] == 2'b00) snap_d = cnt_q;
            end else begin
                src_d = SRC_RAM;
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_RUN:   if (wr_acc && is_reg4) state_d = ST_DRAIN;
            ST_DRAIN: if (empty) state_d = ST_STOPPED;
            default:  state_d = state_q;
        endcase
    end

    always_comb begin
        bus.rdy_out   = rdy;
        bus.rx_ready  = rd_acc && is_reg0 && bus.rx_valid;
        bus.tx_valid  = tx_valid_int;
        bus.tx_data   = tx_valid_int ? mem_q[rd_ptr_q] : 8'h00;
        bus.prog_stop = (state_q == ST_STOPPED);
        case (src_q)
            SRC_RAM: bus.cpu_din = bus.ram_din;
            SRC_RX:  bus.cpu_din = rx_byte_q;
            SRC_CNT: begin
                case (lane_q)
                    2'd0:    bus.cpu_din = snap_q[7:0];
                    2'd1:    bus.cpu_din = snap_q[15:8];
                    2'd2:    bus.cpu_din = snap_q[23:16];
                    default: bus.cpu_din = snap_q[31:24];
                endcase
            end
            default: bus.cpu_din = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= ST_RUN;
            src_q     <= SRC_NONE;
            lane_q    <= '0;
            rx_byte_q <= '0;
            cnt_q     <= '0;
            snap_q    <= '0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            lane_q    <= lane_d;
            rx_byte_q <= rx_byte_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: tb/tb_io_port_bridge.sv
`timescale 1ns/1ps
// Bench for io_port_bridge: table of single bus operations plus hand-written
// fill / stop / reset / snapshot sequences, TX bytes checked via a queue.
module tb_io_port_bridge;
    logic clk = 1'b0;
    logic rst_n;

    io_port_bridge_if bus ();

    io_port_bridge #(.FIFO_DEPTH(16), .CNT_W(32)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0]  exp_tx [$];
    logic [31:0] tb_cnt;

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic        wr;
        logic [7:0]  dout;
        logic        rxv;
        logic [7:0]  rxd;
        logic [7:0]  ram;
        logic        e_rxr;
        logic        push;
        logic [7:0]  pbyte;
        logic        chk_din;
        logic [7:0]  e_din;
    } vec_t;
    vec_t vt [$];

    always @(posedge clk) tb_cnt <= rst_n ? tb_cnt + 32'd1 : 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Each accepted TX handshake must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            if (exp_tx.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_extra: got 0x%0h want none", bus.tx_data);
            end else begin
                chk("tx_byte", bus.tx_data, exp_tx.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] a, input logic wr, input logic [7:0] d);
        bus.cpu_a    = a;
        bus.cpu_wr   = wr;
        bus.cpu_dout = d;
    endtask

    task automatic idle();
        drv(32'h0, 1'b0, 8'h00);
        bus.rx_valid = 1'b0;
    endtask

    task automatic add_v(input string nm, input logic [31:0] a, input logic wr,
                         input logic [7:0] dout, input logic rxv, input logic [7:0] rxd,
                         input logic [7:0] ram, input logic e_rxr, input logic push,
                         input logic [7:0] pbyte, input logic chk_din, input logic [7:0] e_din);
        vec_t v;
        v.nm = nm; v.a = a; v.wr = wr; v.dout = dout; v.rxv = rxv; v.rxd = rxd;
        v.ram = ram; v.e_rxr = e_rxr; v.push = push; v.pbyte = pbyte;
        v.chk_din = chk_din; v.e_din = e_din;
        vt.push_back(v);
    endtask

    task automatic do_reset();
        tick();
        drv(32'h30000, 1'b0, 8'h00);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hAB;
        bus.tx_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_rdy_low", bus.rdy_out, 1'b0);
        chk("rst_rx_ready", bus.rx_ready, 1'b0);
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_prog_stop", bus.prog_stop, 1'b0);
        chk("rst_cpu_din", bus.cpu_din, 8'h00);
        exp_tx.delete();
        idle();
        rst_n = 1'b1;
        #1;
        chk("rst_rdy_high", bus.rdy_out, 1'b1);
    endtask

    task automatic wait_drain(input string nm, input int unsigned lim);
        int unsigned n = 0;
        while (exp_tx.size() != 0 && n < lim) begin
            tick();
            n++;
        end
        chk({nm, "_left"}, exp_tx.size(), 0);
        tick();
        chk({nm, "_txv"}, bus.tx_valid, 1'b0);
    endtask

    task automatic snap_test(input logic [31:0] target);
        int unsigned n = 0;
        while (tb_cnt != target && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL snap_wait: got timeout want count 0x%0h", target);
        end
        drv(32'h30004, 1'b0, 8'h00);
        for (int lane = 1; lane <= 4; lane++) begin
            tick();
            if (lane < 4) drv(32'h30004 + lane, 1'b0, 8'h00);
            else idle();
            #1;
            chk($sformatf("snap_%0h_b%0d", target, lane - 1), bus.cpu_din,
                target[8*(lane-1) +: 8]);
        end
    endtask

    initial begin
        int unsigned n;
        bus.cpu_a = '0; bus.cpu_dout = '0; bus.cpu_wr = 1'b0; bus.ram_din = '0;
        bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b0;
        rst_n = 1'b0;

        do_reset();

        //     name        addr         wr dout  rxv rxd   ram   rxr push byte chk din
        add_v("w48",      32'h30000,   1, 8'h48, 0, 8'h00, 8'h00, 0, 1, 8'h48, 0, 8'h00);
        add_v("w00",      32'h30000,   1, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        add_v("w69",      32'h30000,   1, 8'h69, 0, 8'h00, 8'h00, 0, 1, 8'h69, 0, 8'h00);
        add_v("ram_rd",   32'h01234,   0, 8'h00, 1, 8'h99, 8'hC3, 0, 0, 8'h00, 1, 8'hC3);
        add_v("rx_rd",    32'h30000,   0, 8'h00, 1, 8'h5A, 8'h11, 1, 0, 8'h00, 1, 8'h5A);
        add_v("rx_empty", 32'h30000,   0, 8'h00, 0, 8'h77, 8'h22, 0, 0, 8'h00, 1, 8'h00);
        add_v("rx_lane3", 32'h30003,   0, 8'h00, 1, 8'hA5, 8'h33, 1, 0, 8'h00, 1, 8'hA5);
        add_v("ram_wr",   32'h00100,   1, 8'h55, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        add_v("ram_hi",   32'h20000,   1, 8'h33, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        add_v("ram_01",   32'h10000,   1, 8'h34, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        add_v("alias",    32'h130000,  1, 8'h7E, 0, 8'h00, 8'h00, 0, 1, 8'h7E, 0, 8'h00);
        add_v("w_lane1",  32'h30001,   1, 8'h3C, 0, 8'h00, 8'h00, 0, 1, 8'h3C, 0, 8'h00);
        add_v("ram_rd2",  32'h2FFFF,   0, 8'h00, 1, 8'h42, 8'h6D, 0, 0, 8'h00, 1, 8'h6D);

        bus.tx_ready = 1'b1;
        foreach (vt[i]) begin
            tick();
            drv(vt[i].a, vt[i].wr, vt[i].dout);
            bus.rx_valid = vt[i].rxv;
            bus.rx_data  = vt[i].rxd;
            bus.ram_din  = vt[i].ram;
            #1;
            chk({vt[i].nm, "_rdy"}, bus.rdy_out, 1'b1);
            chk({vt[i].nm, "_rxr"}, bus.rx_ready, vt[i].e_rxr);
            if (vt[i].push) exp_tx.push_back(vt[i].pbyte);
            tick();
            idle();
            #1;
            if (vt[i].chk_din) chk({vt[i].nm, "_din"}, bus.cpu_din, vt[i].e_din);
        end
        tick();
        idle();
        wait_drain("tbl", 40);

        // Back-to-back writes: push and pop land on the same edge.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'h21 + 8'(i);
            tick();
            drv(32'h30000, 1'b1, b);
            #1;
            chk("pp_rdy", bus.rdy_out, 1'b1);
            exp_tx.push_back(b);
        end
        tick();
        idle();
        wait_drain("pp", 10);

        // Fill to capacity with TX blocked, then one pop frees a slot.
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            drv(32'h30000, 1'b1, 8'(i));
            #1;
            chk("fill_rdy", bus.rdy_out, 1'b1);
            exp_tx.push_back(8'(i));
        end
        tick();
        drv(32'h30000, 1'b1, 8'h11);
        #1;
        chk("full_stall", bus.rdy_out, 1'b0);
        tick();
        chk("full_hold", bus.rdy_out, 1'b0);
        bus.tx_ready = 1'b1;
        #1;
        chk("no_lookahead", bus.rdy_out, 1'b0);
        tick();
        bus.tx_ready = 1'b0;
        #1;
        chk("space_rdy", bus.rdy_out, 1'b1);
        exp_tx.push_back(8'h11);
        tick();
        idle();
        bus.tx_ready = 1'b1;
        wait_drain("fill", 40);

        // Stop sequence: queued bytes, then the reg4 marker, then STOPPED.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            drv(32'h30000, 1'b1, 8'h31 + 8'(i));
            #1;
            exp_tx.push_back(8'h31 + 8'(i));
        end
        tick();
        drv(32'h30004, 1'b1, 8'hEE);
        #1;
        chk("stop_wr_rdy", bus.rdy_out, 1'b1);
        exp_tx.push_back(8'h00);
        tick();
        drv(32'h30000, 1'b0, 8'h00);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h66;
        #1;
        chk("drain_rdy", bus.rdy_out, 1'b0);
        chk("drain_no_pop", bus.rx_ready, 1'b0);
        chk("drain_stop_lo", bus.prog_stop, 1'b0);
        chk("drain_txv", bus.tx_valid, 1'b1);
        bus.tx_ready = 1'b1;
        n = 0;
        while (bus.tx_valid === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("stop_empty", bus.tx_valid, 1'b0);
        chk("stop_early", bus.prog_stop, 1'b0);
        tick();
        chk("stop_set", bus.prog_stop, 1'b1);
        chk("stop_rdy", bus.rdy_out, 1'b0);
        drv(32'h30000, 1'b1, 8'h44);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stop_hold", bus.prog_stop, 1'b1);
            chk("stop_txv", bus.tx_valid, 1'b0);
            chk("stop_hold_rdy", bus.rdy_out, 1'b0);
        end
        chk("stop_left", exp_tx.size(), 0);
        idle();

        // Reset while draining throws away the queue and the stop state.
        do_reset();
        tick();
        drv(32'h30000, 1'b1, 8'h51);
        #1;
        exp_tx.push_back(8'h51);
        tick();
        drv(32'h30004, 1'b1, 8'hEE);
        #1;
        exp_tx.push_back(8'h00);
        tick();
        idle();
        #1;
        chk("md_drain_rdy", bus.rdy_out, 1'b0);
        chk("md_txv", bus.tx_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("md_rst_txv", bus.tx_valid, 1'b0);
        chk("md_rst_txd", bus.tx_data, 8'h00);
        chk("md_rst_stop", bus.prog_stop, 1'b0);
        chk("md_rst_rdy", bus.rdy_out, 1'b0);
        exp_tx.delete();
        rst_n = 1'b1;
        drv(32'h30004, 1'b0, 8'h00);
        #1;
        chk("md_rdy", bus.rdy_out, 1'b1);
        tick();
        idle();
        #1;
        chk("md_cnt0", bus.cpu_din, 8'h00);
        tick();
        drv(32'h30000, 1'b1, 8'h61);
        bus.tx_ready = 1'b1;
        #1;
        chk("md_wr_rdy", bus.rdy_out, 1'b1);
        exp_tx.push_back(8'h61);
        tick();
        idle();
        wait_drain("md", 10);

        // Counter snapshot: lane 0 captures, lanes 1-3 replay the same value.
        do_reset();
        snap_test(32'h0000_00FF);
        snap_test(32'h0000_03A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
